// File: rtl/keypad_encoder.sv
// Scans a 4x3 active-low keypad, debounces presses and emits one-cycle timer commands.
// Define KEYPAD_DIGIT_LIMIT_EN to cap digit strobes at three until '*' or '#' is accepted.

module keypad_encoder #(
    parameter int unsigned COL_DWELL       = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       en,
    input  logic [3:0] rows,
    output logic [2:0] cols,
    output logic [3:0] data,
    output logic       loadn,
    output logic       key_clear,
    output logic       key_start
);

    localparam int unsigned DwellW = (COL_DWELL > 1) ? $clog2(COL_DWELL) : 1;
    localparam int unsigned CntW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DwellW-1:0] DwellLast = DwellW'(COL_DWELL - 1);
    localparam logic [CntW-1:0]   CntLast   = CntW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        StScan,
        StDebounce,
        StEmit,
        StWaitRelease
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        col_q, col_d;
    logic [1:0]        row_q, row_d;
    logic [DwellW-1:0] dwell_q, dwell_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [3:0]        data_q, data_d;
    logic [3:0]        rows_meta_q, rows_meta_d;
    logic [3:0]        rows_s_q, rows_s_d;
    logic [2:0]        cols_p1_q, cols_p1_d;
    logic [2:0]        cols_p2_q, cols_p2_d;

    logic [1:0] next_col;
    logic [1:0] low_row;
    logic [1:0] hit_col;
    logic       hit_valid;
    logic       is_star;
    logic       is_hash;
    logic       is_digit;
    logic [3:0] digit;
    logic       digit_ok;
    logic       emit;

`ifdef KEYPAD_DIGIT_LIMIT_EN
    logic [1:0] digit_cnt_q, digit_cnt_d;

    always_comb begin
        digit_ok = (digit_cnt_q != 2'd3);
    end
`else
    always_comb begin
        digit_ok = 1'b1;
    end
`endif

    // Column drive pipeline tracks which column produced the sample now in rows_s_q.
    always_comb begin
        rows_meta_d = rows;
        rows_s_d    = rows_meta_q;
        cols_p1_d   = cols;
        cols_p2_d   = cols_p1_q;
    end

    always_comb begin
        next_col = (col_q == 2'd2) ? 2'd0 : col_q + 2'd1;

        low_row = 2'd3;
        if (!rows_s_q[0]) begin
            low_row = 2'd0;
        end else if (!rows_s_q[1]) begin
            low_row = 2'd1;
        end else if (!rows_s_q[2]) begin
            low_row = 2'd2;
        end

        hit_valid = 1'b1;
        hit_col   = 2'd0;
        unique case (cols_p2_q)
            3'b110:  hit_col = 2'd0;
            3'b101:  hit_col = 2'd1;
            3'b011:  hit_col = 2'd2;
            default: hit_valid = 1'b0;
        endcase

        is_star  = (row_q == 2'd3) && (col_q == 2'd0);
        is_hash  = (row_q == 2'd3) && (col_q == 2'd2);
        is_digit = !is_star && !is_hash;
        digit    = (row_q == 2'd3) ? 4'd0
                                   : ({2'b00, row_q} * 4'd3) + {2'b00, col_q} + 4'd1;
        emit     = (state_q == StEmit) && en;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        dwell_d = dwell_q;
        cnt_d   = cnt_q;
        data_d  = (emit && is_digit && digit_ok) ? digit : data_q;

        unique case (state_q)
            StScan: begin
                if (dwell_q == DwellLast) begin
                    dwell_d = '0;
                    if (hit_valid && (rows_s_q != 4'b1111)) begin
                        // The triggering sample already counts as the first stable one.
                        col_d   = hit_col;
                        row_d   = low_row;
                        cnt_d   = CntW'(1);
                        state_d = (CntLast == '0) ? StEmit : StDebounce;
                    end else begin
                        col_d = next_col;
                    end
                end else begin
                    dwell_d = dwell_q + DwellW'(1);
                end
            end
            StDebounce: begin
                // Samples still in flight from the previous column are skipped.
                if (cols_p2_q == cols) begin
                    if (!rows_s_q[row_q]) begin
                        cnt_d = cnt_q + CntW'(1);
                        if (cnt_q == CntLast) begin
                            state_d = StEmit;
                        end
                    end else begin
                        state_d = StScan;
                        col_d   = next_col;
                        dwell_d = '0;
                        cnt_d   = '0;
                    end
                end
            end
            StEmit: begin
                state_d = StWaitRelease;
                cnt_d   = '0;
            end
            StWaitRelease: begin
                if ((cols_p2_q == 3'b000) && (rows_s_q == 4'b1111)) begin
                    if (cnt_q == CntLast) begin
                        state_d = StScan;
                        col_d   = 2'd0;
                        dwell_d = '0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            default: begin
                state_d = StScan;
            end
        endcase

        if (!en) begin
            state_d = StWaitRelease;
            cnt_d   = '0;
        end
    end

`ifdef KEYPAD_DIGIT_LIMIT_EN
    always_comb begin
        digit_cnt_d = digit_cnt_q;
        if (emit) begin
            if (is_digit) begin
                if (digit_ok) begin
                    digit_cnt_d = digit_cnt_q + 2'd1;
                end
            end else begin
                digit_cnt_d = 2'd0;
            end
        end
    end
`endif

    // Outputs
    always_comb begin
        cols      = 3'b000;
        loadn     = 1'b1;
        key_clear = 1'b0;
        key_start = 1'b0;
        data      = data_d;

        if (state_q != StWaitRelease) begin
            unique case (col_q)
                2'd0:    cols = 3'b110;
                2'd1:    cols = 3'b101;
                default: cols = 3'b011;
            endcase
        end

        if (emit) begin
            loadn     = !(is_digit && digit_ok);
            key_clear = is_star;
            key_start = is_hash;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q     <= StScan;
            col_q       <= 2'd0;
            row_q       <= 2'd0;
            dwell_q     <= '0;
            cnt_q       <= '0;
            data_q      <= 4'd0;
            rows_meta_q <= 4'b1111;
            rows_s_q    <= 4'b1111;
            cols_p1_q   <= 3'b111;
            cols_p2_q   <= 3'b111;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            dwell_q     <= dwell_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            rows_meta_q <= rows_meta_d;
            rows_s_q    <= rows_s_d;
            cols_p1_q   <= cols_p1_d;
            cols_p2_q   <= cols_p2_d;
        end
    end

`ifdef KEYPAD_DIGIT_LIMIT_EN
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            digit_cnt_q <= 2'd0;
        end else begin
            digit_cnt_q <= digit_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_keypad_encoder.sv
// Directed bench for keypad_encoder: a keypad model drives rows from cols, and a scoreboard
// queue of expected strobes is checked by a negedge monitor.

module tb_keypad_encoder;

    localparam int unsigned COL_DWELL       = 2;
    localparam int unsigned DEBOUNCE_CYCLES = 4;
    localparam int LAT_MAX  = 2 + 3 * COL_DWELL + DEBOUNCE_CYCLES + 1;
    localparam int REL_WAIT = 2 * DEBOUNCE_CYCLES + 4;

    logic       clk  = 1'b0;
    logic       clrn = 1'b0;
    logic       en   = 1'b1;
    logic [3:0] rows;
    logic [2:0] cols;
    logic [3:0] data;
    logic       loadn;
    logic       key_clear;
    logic       key_start;

    // Bit r*3+c set means key (row r, col c) is held.
    logic [11:0] key_mask = '0;

    int tests_run    = 0;
    int tests_failed = 0;
    int ev_count     = 0;

    logic [5:0] exp_q[$];  // {kind, data}: kind 0 = loadn, 1 = clear, 2 = start
    logic [3:0] exp_data = 4'd0;
    logic [1:0] mon_kind;
    logic [5:0] mon_obs;
    logic [5:0] mon_exp;
`ifdef KEYPAD_DIGIT_LIMIT_EN
    int digit_cnt = 0;
`endif

    always #5 clk = ~clk;

    always_comb begin
        rows = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (key_mask[r * 3 + c] && !cols[c]) rows[r] = 1'b0;
            end
        end
    end

    keypad_encoder #(
        .COL_DWELL       (COL_DWELL),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) dut (
        .clk       (clk),
        .clrn      (clrn),
        .en        (en),
        .rows      (rows),
        .cols      (cols),
        .data      (data),
        .loadn     (loadn),
        .key_clear (key_clear),
        .key_start (key_start)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] digit_of(input int idx);
        return (idx == 10) ? 4'd0 : 4'(idx + 1);
    endfunction

    // Monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (clrn === 1'b1 && (loadn === 1'b0 || key_clear === 1'b1 || key_start === 1'b1)) begin
            check("exclusive", 32'($countones({~loadn, key_clear, key_start})), 32'd1);
            if (loadn === 1'b0) mon_kind = 2'd0;
            else if (key_clear === 1'b1) mon_kind = 2'd1;
            else mon_kind = 2'd2;
            mon_obs = {mon_kind, data};
            if (exp_q.size() != 0) mon_exp = exp_q.pop_front();
            else mon_exp = 6'h3f;
            check("strobe", 32'(mon_obs), 32'(mon_exp));
            ev_count++;
        end
    end

    task automatic expect_key(input int idx, output bit strobe);
        strobe = 1'b1;
        if (idx == 9 || idx == 11) begin
            exp_q.push_back({(idx == 9) ? 2'd1 : 2'd2, exp_data});
`ifdef KEYPAD_DIGIT_LIMIT_EN
            digit_cnt = 0;
`endif
        end else begin
`ifdef KEYPAD_DIGIT_LIMIT_EN
            strobe = (digit_cnt < 3);
            if (strobe) digit_cnt++;
`endif
            if (strobe) begin
                exp_data = digit_of(idx);
                exp_q.push_back({2'd0, exp_data});
            end
        end
    endtask

    task automatic wait_strobe(input int start, input bit strobe, input string tag);
        for (int i = 0; i < LAT_MAX && ev_count == start; i++) begin
            @(negedge clk);
            #1;
        end
        check(tag, 32'(ev_count - start), strobe ? 32'd1 : 32'd0);
    endtask

    task automatic tap(input int idx, input string tag);
        bit strobe;
        int start;
        expect_key(idx, strobe);
        start = ev_count;
        key_mask[idx] = 1'b1;
        wait_strobe(start, strobe, {tag, "_latency"});
        check({tag, "_data"}, 32'(data), 32'(exp_data));
        repeat (6) @(negedge clk);
        #1 check({tag, "_cols_held"}, 32'(cols), 32'(3'b000));
        key_mask[idx] = 1'b0;
        repeat (REL_WAIT) @(negedge clk);
        #1 check({tag, "_data_hold"}, 32'(data), 32'(exp_data));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cols"}, 32'(cols), 32'(3'b110));
        check({tag, "_data"}, 32'(data), 32'd0);
        check({tag, "_loadn"}, 32'(loadn), 32'd1);
        check({tag, "_clear"}, 32'(key_clear), 32'd0);
        check({tag, "_start"}, 32'(key_start), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    initial begin
        int  start;
        int  run;
        bit  found;
        bit  strobe;

        // Reset values
        repeat (3) @(negedge clk);
        #1 check_reset_outputs("reset");

        // Keys 2 and 9 together from a fresh scan: column 1 is reached first
        @(negedge clk);
        clrn = 1'b1;
        expect_key(1, strobe);
        start = ev_count;
        key_mask[1] = 1'b1;
        key_mask[8] = 1'b1;
        wait_strobe(start, strobe, "multi_first");
        check("multi_data", 32'(data), 32'd2);
        key_mask[1] = 1'b0;
        start = ev_count;
        repeat (25) @(negedge clk);
        #1 check("multi_held9", 32'(ev_count - start), 32'd0);
        key_mask[8] = 1'b0;
        repeat (REL_WAIT) @(negedge clk);
        tap(8, "key9_repress");

        // Single stable key 5
        tap(4, "key5");

        // Short bounce on key 1
        start = ev_count;
        key_mask[0] = 1'b1;
        repeat (2) @(negedge clk);
        key_mask[0] = 1'b0;
        repeat (20) @(negedge clk);
        #1 check("bounce", 32'(ev_count - start), 32'd0);

        // Sequence 4, 5, 7
        tap(3, "seq4");
        tap(4, "seq5");
        tap(6, "seq7");

        // '*' then '#'
        tap(9, "star");
        tap(11, "hash");

        // Four digits, then '*' and 6
        tap(0, "lim1");
        tap(1, "lim2");
        tap(2, "lim3");
        tap(3, "lim4");
        tap(9, "lim_star");
        tap(5, "lim6");

        // en low while 8 is held, raised while still held
        @(negedge clk);
        en = 1'b0;
        key_mask[7] = 1'b1;
        repeat (10) @(negedge clk);
        en = 1'b1;
        start = ev_count;
        repeat (25) @(negedge clk);
        #1 check("en_held8", 32'(ev_count - start), 32'd0);
        key_mask[7] = 1'b0;
        repeat (REL_WAIT) @(negedge clk);
        tap(7, "key8_repress");

        // Reset during DEBOUNCE on key 3 (column 2 held longer than one dwell)
        key_mask[2] = 1'b1;
        run   = 0;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            #1;
            if (cols === 3'b011) run++;
            else run = 0;
            if (run >= 3) found = 1'b1;
        end
        check("debounce_reached", 32'(found), 32'd1);
        clrn = 1'b0;
        #1 check_reset_outputs("async_reset");
        key_mask = '0;
        exp_data = 4'd0;
`ifdef KEYPAD_DIGIT_LIMIT_EN
        digit_cnt = 0;
`endif
        repeat (2) @(negedge clk);
        clrn = 1'b1;
        repeat (5) @(negedge clk);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
